// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Steps a convolution unit through the windows of one layer pass. For each
//   window it clears the unit for one cycle, then waits ACC = D*F + PE_LAT
//   cycles for the result. It captures the result, with optional ReLU, and
//   holds it on a valid/ready output until downstream accepts it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      request one pass (accepted only while idle)
//   num_win    number of windows, sampled on start acceptance
//   cu_reset   active-low clear to the convolution unit
//   win_idx    current window index (slice select for the convolution unit)
//   cu_result  signed result from the convolution unit
//   out_data   captured (optionally clamped) result
//   out_idx    window index belonging to out_data
//   out_valid  out_data/out_idx valid
//   out_ready  downstream accept
//   busy       pass in progress
//   done       one-cycle end-of-pass pulse
module conv_window_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 64,
  parameter int PE_LAT     = 2,
  parameter int IDX_W      = 10,
  parameter int RELU       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_W-1:0]      num_win,
  output logic                  cu_reset,
  output logic [IDX_W-1:0]      win_idx,
  input  logic [DATA_WIDTH-1:0] cu_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC   = D * F + PE_LAT;
  localparam int CNT_W = (ACC > 1) ? $clog2(ACC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_r,     state_s;
  logic [IDX_W-1:0]      num_lat_r,   num_lat_s;
  logic [IDX_W-1:0]      win_idx_r,   win_idx_s;
  logic [CNT_W-1:0]      cnt_r,       cnt_s;
  logic [DATA_WIDTH-1:0] out_data_r,  out_data_s;
  logic [IDX_W-1:0]      out_idx_r,   out_idx_s;
  logic                  out_valid_r, out_valid_s;
  logic                  busy_r,      busy_s;
  logic                  done_r,      done_s;
  logic                  cu_reset_r,  cu_reset_s;

  // Next-state and next-output logic; every output is registered, so
  // cu_reset_s is low exactly when the next state is CLEAR.
  always_comb begin
    state_s     = state_r;
    num_lat_s   = num_lat_r;
    win_idx_s   = win_idx_r;
    cnt_s       = cnt_r;
    out_data_s  = out_data_r;
    out_idx_s   = out_idx_r;
    out_valid_s = out_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    cu_reset_s  = 1'b1;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (num_win != IDX_ZERO) begin
            num_lat_s  = num_win;
            win_idx_s  = IDX_ZERO;
            cnt_s      = CNT_ZERO;
            busy_s     = 1'b1;
            cu_reset_s = 1'b0;
            state_s    = CLEAR;
          end else begin
            // Empty pass: report completion without touching the unit.
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        cnt_s   = CNT_ZERO;
        state_s = RUN;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          // Result is valid on cu_result during the last accumulate cycle.
          if ((RELU != 0) && cu_result[DATA_WIDTH-1]) begin
            out_data_s = DATA_ZERO;
          end else begin
            out_data_s = cu_result;
          end
          out_idx_s   = win_idx_r;
          out_valid_s = 1'b1;
          state_s     = HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (win_idx_r == (num_lat_r - IDX_ONE)) begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            win_idx_s  = win_idx_r + IDX_ONE;
            cu_reset_s = 1'b0;
            state_s    = CLEAR;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      num_lat_r   <= IDX_ZERO;
      win_idx_r   <= IDX_ZERO;
      cnt_r       <= CNT_ZERO;
      out_data_r  <= DATA_ZERO;
      out_idx_r   <= IDX_ZERO;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cu_reset_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      num_lat_r   <= num_lat_s;
      win_idx_r   <= win_idx_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_idx_r   <= out_idx_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      cu_reset_r  <= cu_reset_s;
    end
  end

  assign cu_reset  = cu_reset_r;
  assign win_idx   = win_idx_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer at default parameters.
// Two instances share all inputs: dut (RELU=1) and dut_nr (RELU=0).
// A window-age model predicts every output each cycle. Hand-computed
// literals pin the key timings and values.
module tb_conv_window_sequencer;

  localparam int ACC = 66;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  num_win;
  logic [15:0] cu_result;
  logic        out_ready;

  logic        cu_reset,  nr_cu_reset;
  logic [9:0]  win_idx,   nr_win_idx;
  logic [15:0] out_data,  nr_out_data;
  logic [9:0]  out_idx,   nr_out_idx;
  logic        out_valid, nr_out_valid;
  logic        busy,      nr_busy;
  logic        done,      nr_done;

  int checks;
  int failures;
  int cyc;

  // model state: a window's age is the number of cycles since its clear cycle
  bit          m_active;
  bit          m_valid;
  bit          m_busy;
  bit          m_done;
  bit          m_cu_reset;
  int          m_win;
  int          m_num;
  int          m_age;
  int          m_idx;
  logic [15:0] m_data;
  logic [15:0] m_data_nr;

  conv_window_sequencer #(.RELU(1)) dut (
    .clk(clk), .reset(reset), .start(start), .num_win(num_win),
    .cu_reset(cu_reset), .win_idx(win_idx), .cu_result(cu_result),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  conv_window_sequencer #(.RELU(0)) dut_nr (
    .clk(clk), .reset(reset), .start(start), .num_win(num_win),
    .cu_reset(nr_cu_reset), .win_idx(nr_win_idx), .cu_result(cu_result),
    .out_data(nr_out_data), .out_idx(nr_out_idx), .out_valid(nr_out_valid),
    .out_ready(out_ready), .busy(nr_busy), .done(nr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_active = 0; m_valid = 0; m_busy = 0; m_done = 0; m_cu_reset = 0;
      m_win = 0; m_idx = 0; m_age = 0; m_data = 16'h0000; m_data_nr = 16'h0000;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin
          if (num_win == 10'd0) begin
            m_done = 1;
          end else begin
            m_active = 1; m_num = int'(num_win); m_win = 0; m_age = 0; m_valid = 0;
          end
        end
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          if (m_win == m_num - 1) begin
            m_active = 0; m_done = 1;
          end else begin
            m_win = m_win + 1; m_age = 0;
          end
        end
      end else begin
        m_age = m_age + 1;
        if (m_age == ACC + 1) begin
          m_valid   = 1;
          m_data_nr = cu_result;
          m_data    = cu_result[15] ? 16'h0000 : cu_result;
          m_idx     = m_win;
        end
      end
      m_cu_reset = !(m_active && !m_valid && m_age == 0);
      m_busy     = m_active;
    end
  endtask

  // one clock: model follows the edge, outputs are compared at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("out_valid",    out_valid,    m_valid);
    chk("out_data",     out_data,     m_data);
    chk("out_idx",      out_idx,      m_idx);
    chk("win_idx",      win_idx,      m_win);
    chk("busy",         busy,         m_busy);
    chk("done",         done,         m_done);
    chk("cu_reset",     cu_reset,     m_cu_reset);
    chk("nr_out_valid", nr_out_valid, m_valid);
    chk("nr_out_data",  nr_out_data,  m_data_nr);
    chk("nr_out_idx",   nr_out_idx,   m_idx);
    chk("nr_win_idx",   nr_win_idx,   m_win);
    chk("nr_busy",      nr_busy,      m_busy);
    chk("nr_done",      nr_done,      m_done);
    chk("nr_cu_reset",  nr_cu_reset,  m_cu_reset);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for out_valid cycle=%0d", name, cyc);
    end
  endtask

  initial begin
    int n;
    int hold;
    int xfers;
    int dones;
    int xidx[4];
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; num_win = 10'd0; cu_result = 16'h0000; out_ready = 1'b0;

    // reset held for three cycles
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cu_reset",  cu_reset,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_out_data",  out_data,  16'h0000);
    chk("rst_win_idx",   win_idx,   10'd0);
    reset = 1'b1;
    step();
    chk("rel_cu_reset", cu_reset, 1'b1);
    chk("rel_busy",     busy,     1'b0);

    // single window, positive result
    start = 1'b1; num_win = 10'd1; cu_result = 16'h0123; out_ready = 1'b1;
    step();
    start = 1'b0; num_win = 10'($urandom_range(0, 1023));
    chk("sw_clear_cu_reset", cu_reset, 1'b0);
    n = 1;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("sw_latency", n, 68);
    chk("sw_data",    out_data, 16'h0123);
    chk("sw_idx",     out_idx,  10'd0);
    step();
    chk("sw_done", done, 1'b1);
    chk("sw_busy", busy, 1'b0);

    // negative result, clamped only with RELU
    start = 1'b1; num_win = 10'd1; cu_result = 16'hF000;
    step();
    start = 1'b0;
    wait_valid("neg");
    chk("neg_relu1", out_data,    16'h0000);
    chk("neg_relu0", nr_out_data, 16'hF000);
    repeat (2) step();

    // empty pass
    start = 1'b1; num_win = 10'd0;
    step();
    start = 1'b0;
    chk("zero_done",     done,     1'b1);
    chk("zero_busy",     busy,     1'b0);
    chk("zero_cu_reset", cu_reset, 1'b1);
    repeat (5) begin
      step();
      chk("zero_no_valid", out_valid, 1'b0);
    end

    // backpressure: three windows, window 1 stalled for five cycles
    start = 1'b1; num_win = 10'd3; out_ready = 1'b1;
    step();
    start = 1'b0;
    hold = 0; xfers = 0; dones = 0;
    for (int k = 0; k < 400 && dones == 0; k++) begin
      cu_result = 16'($urandom);
      out_ready = !(out_valid && out_idx == 10'd1 && hold < 5);
      if (out_valid && !out_ready) hold++;
      if (out_valid && out_ready) begin
        if (xfers < 4) xidx[xfers] = int'(out_idx);
        xfers++;
      end
      step();
      if (done) dones++;
    end
    out_ready = 1'b1;
    repeat (3) begin
      step();
      if (done) dones++;
    end
    chk("bp_xfers", xfers, 3);
    chk("bp_idx0",  xidx[0], 0);
    chk("bp_idx1",  xidx[1], 1);
    chk("bp_idx2",  xidx[2], 2);
    chk("bp_hold",  hold, 5);
    chk("bp_dones", dones, 1);

    // abort at RUN cycle 30
    start = 1'b1; num_win = 10'd2;
    step();
    start = 1'b0;
    step();
    repeat (29) step();
    reset = 1'b0;
    step();
    chk("ab_out_valid", out_valid, 1'b0);
    chk("ab_cu_reset",  cu_reset,  1'b0);
    chk("ab_busy",      busy,      1'b0);
    chk("ab_win_idx",   win_idx,   10'd0);
    chk("ab_out_data",  out_data,  16'h0000);
    chk("ab_out_idx",   out_idx,   10'd0);
    reset = 1'b1;
    repeat (100) begin
      step();
      chk("ab_no_valid", out_valid, 1'b0);
    end

    // retrigger; a start while busy must not change the window count
    start = 1'b1; num_win = 10'd2;
    step();
    start = 1'b0;
    repeat (10) step();
    start = 1'b1; num_win = 10'd5;
    step();
    start = 1'b0;
    xfers = 0; dones = 0;
    for (int k = 0; k < 400 && dones == 0; k++) begin
      if (out_valid && out_ready) xfers++;
      step();
      if (done) dones++;
    end
    chk("rt_xfers", xfers, 2);
    chk("rt_dones", dones, 1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 599) != 0);
      start     = ($urandom_range(0, 19) == 0);
      num_win   = 10'($urandom_range(0, 3));
      cu_result = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the result and output data.
REQ-002 SHALL have parameter D, default 1: filter depth of the driven convolution unit.
REQ-003 SHALL have parameter F, default 64: filter size of the driven convolution unit.
REQ-004 SHALL have parameter PE_LAT, default 2: extra cycles from the last multiply-accumulate input to a valid convolution result.
REQ-005 SHALL have parameter IDX_W, default 10: width of window count and index.
REQ-006 SHALL have parameter RELU, default 1: when 1, negative results are clamped to zero.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-009 SHALL have port start, input, 1: request to process one layer pass.
REQ-010 SHALL have port num_win, input, IDX_W: number of windows in the pass, sampled when start is accepted.
REQ-011 SHALL have port cu_reset, output, 1: active-low synchronous clear to the convolution unit.
REQ-012 SHALL have port win_idx, output, IDX_W: current window index; selects the signal slice fed to the convolution unit.
REQ-013 SHALL have port cu_result, input, DATA_WIDTH: signed two's-complement result from the convolution unit.
REQ-014 SHALL have port out_data, output, DATA_WIDTH: captured and optionally ReLU-clamped result.
REQ-015 SHALL have port out_idx, output, IDX_W: window index belonging to out_data.
REQ-016 SHALL have port out_valid, output, 1: out_data and out_idx are valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts; transfer occurs when out_valid and out_ready are both 1.
REQ-018 SHALL have port busy, output, 1: a pass is in progress.
REQ-019 SHALL have port done, output, 1: one-cycle pulse at the end of a pass.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, RUN and HOLD; define ACC = D*F + PE_LAT.
REQ-021 IDLE with start=1 and num_win>0 SHALL latch num_win, set win_idx=0, set busy=1 and go to CLEAR.
REQ-022 IDLE with start=1 and num_win=0 SHALL pulse done in the next cycle, keep busy=0, issue no cu_reset pulse and produce no output.
REQ-023 CLEAR SHALL last exactly 1 cycle with cu_reset=0, then go to RUN.
REQ-024 RUN SHALL hold cu_reset=1 for exactly ACC cycles, counted by a cycle counter sized to hold ACC-1; win_idx SHALL be stable throughout CLEAR and RUN.
REQ-025 On the clock edge ending the last RUN cycle, the block SHALL register out_data = (RELU && cu_result MSB=1) ? 0 : cu_result, set out_idx=win_idx and out_valid=1, and go to HOLD.
REQ-026 The first out_valid of a pass SHALL therefore be high in cycle T+ACC+2, where T is the start-accept cycle (T+68 at default parameters).
REQ-027 In HOLD, out_valid, out_data and out_idx SHALL remain stable until a transfer occurs; out_ready high outside HOLD SHALL have no effect.
REQ-028 A transfer on a window where win_idx < latched num_win-1 SHALL clear out_valid, increment win_idx and go to CLEAR in the next cycle.
REQ-029 A transfer on the last window SHALL clear out_valid and busy and return to IDLE; done SHALL be 1 in the cycle following the transfer.
REQ-030 Start SHALL be ignored while busy=1, including in the done cycle's preceding states; changes to num_win after acceptance SHALL be ignored.
REQ-031 Outside CLEAR, cu_reset SHALL be 1, except during and after reset (see REQ-032).

Reset
REQ-032 reset=0 at any clock edge, including mid-pass, SHALL force state IDLE, cu_reset=0, win_idx=0, out_idx=0, out_data=0, out_valid=0, busy=0, done=0 and cycle counter=0; cu_reset SHALL return to 1 in the first IDLE cycle after reset is released.
REQ-033 After reset is released, a new start SHALL be accepted normally; no partial result from the aborted pass SHALL be output.

Verification (D=1, F=64, PE_LAT=2, ACC=66)
REQ-034 Hold reset low for 3 cycles -> all outputs 0 (cu_reset=0); release -> cu_reset=1 and busy=0.
REQ-035 Single window: start with num_win=1 at T, cu_result=16'h0123 -> cu_reset=0 only in T+1; out_valid rises at T+68 with out_data=16'h0123 and out_idx=0; with out_ready=1, done=1 one cycle after the transfer and busy=0.
REQ-036 Negative result: cu_result=16'hF000 -> out_data=16'h0000 with RELU=1, and out_data=16'hF000 with RELU=0.
REQ-037 Backpressure: num_win=3, out_ready low for 5 cycles during window 1 -> out_data and out_idx=1 held stable; win_idx steps 0,1,2; exactly 3 transfers with out_idx 0,1,2; exactly one done pulse.
REQ-038 num_win=0 -> done=1 at T+1, busy stays 0, cu_reset stays 1, out_valid never rises.
REQ-039 Abort and retrigger: reset asserted at RUN cycle 30 -> all outputs take REQ-032 values and no output appears; start pulsed while busy=1 -> ignored and latched num_win unchanged; a new start after idle -> a normal pass.
